// File: rtl/pix_clk_rst_ctrl.sv
// Pixel-clock reset sequencer and PLL lock monitor.
// Synchronises raw PLL lock, filters it, holds resets, then releases
// N_RESETS active-low channels in staggered order; tracks lock loss in RUN.
module pix_clk_rst_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FILTER = 16,
    parameter int RESET_HOLD  = 8,
    parameter int N_RESETS    = 3,
    parameter int STAGGER     = 4,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pll_lock,
    input  logic                soft_rst_req,
    input  logic                clr_lost,
    output logic [N_RESETS-1:0] rst_n_out,
    output logic                ready,
    output logic                lock_lost,
    output logic [CNT_W-1:0]    loss_count,
    output logic [2:0]          state_dbg
);

    localparam int REL_LAST = (N_RESETS - 1) * STAGGER;
    localparam int MAX_AB   = (LOCK_FILTER > RESET_HOLD) ? LOCK_FILTER : RESET_HOLD;
    localparam int CNT_MAX  = (MAX_AB > REL_LAST + 1) ? MAX_AB : REL_LAST + 1;
    localparam int CW       = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILTER  = 3'd1,
        HOLD    = 3'd2,
        RELEASE = 3'd3,
        RUN     = 3'd4,
        LOST    = 3'd5
    } state_t;

    state_t                  state, state_nx;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    lock_s;
    logic [CW-1:0]           cnt, cnt_nx;
    logic [N_RESETS-1:0]     rst_n_nx;
    logic                    ready_nx;
    logic                    loss_ev;
    logic                    lock_lost_nx;
    logic [CNT_W-1:0]        loss_count_nx;

    assign lock_s    = sync_q[SYNC_STAGES-1];
    assign state_dbg = state;

    // Bring the asynchronous PLL lock into the pixel clock domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
        end
    end

    // State, shared phase counter and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rst_n_out  <= '0;
            ready      <= 1'b0;
            lock_lost  <= 1'b0;
            loss_count <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            rst_n_out  <= rst_n_nx;
            ready      <= ready_nx;
            lock_lost  <= lock_lost_nx;
            loss_count <= loss_count_nx;
        end
    end

    // Next-state, counter and output decode; lock loss outranks soft reset.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rst_n_nx = rst_n_out;
        ready_nx = 1'b0;
        loss_ev  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx   = '0;
                rst_n_nx = '0;
                if (lock_s) state_nx = FILTER;
            end
            FILTER: begin
                rst_n_nx = '0;
                if (!lock_s) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == CW'(LOCK_FILTER - 1)) begin
                    state_nx = HOLD;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            HOLD: begin
                rst_n_nx = '0;
                if (!lock_s) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == CW'(RESET_HOLD - 1)) begin
                    state_nx = RELEASE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            RELEASE: begin
                if (!lock_s) begin
                    state_nx = IDLE;
                    rst_n_nx = '0;
                    cnt_nx   = '0;
                end else if (soft_rst_req) begin
                    state_nx = HOLD;
                    rst_n_nx = '0;
                    cnt_nx   = '0;
                end else begin
                    for (int unsigned i = 0; i < N_RESETS; i++) begin
                        if (cnt == CW'(i * STAGGER)) rst_n_nx[i] = 1'b1;
                    end
                    if (cnt == CW'(REL_LAST)) begin
                        state_nx = RUN;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_nx = LOST;
                    rst_n_nx = '0;
                    loss_ev  = 1'b1;
                end else if (soft_rst_req) begin
                    state_nx = HOLD;
                    rst_n_nx = '0;
                    cnt_nx   = '0;
                end else begin
                    rst_n_nx = '1;
                    ready_nx = 1'b1;
                end
            end
            LOST: begin
                state_nx = IDLE;
                rst_n_nx = '0;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = IDLE;
                rst_n_nx = '0;
                cnt_nx   = '0;
            end
        endcase
    end

    // Sticky loss flag (set beats clear) and saturating loss counter.
    always_comb begin
        lock_lost_nx  = lock_lost;
        loss_count_nx = loss_count;
        if (loss_ev) begin
            lock_lost_nx = 1'b1;
            if (loss_count != '1) loss_count_nx = loss_count + CNT_W'(1);
        end else if (clr_lost) begin
            lock_lost_nx = 1'b0;
        end
    end

endmodule

// File: tb/tb_pix_clk_rst_ctrl.sv
// Directed self-checking bench for pix_clk_rst_ctrl (default parameters),
// plus a CNT_W=2 instance sharing the stimulus to observe counter saturation.
module tb_pix_clk_rst_ctrl;

    logic       clk;
    logic       rst;
    logic       pll_lock;
    logic       soft_rst_req;
    logic       clr_lost;
    logic [2:0] rst_n_out;
    logic       ready;
    logic       lock_lost;
    logic [7:0] loss_count;
    logic [2:0] state_dbg;

    logic [2:0] sat_rst_n_out;
    logic       sat_ready;
    logic       sat_lock_lost;
    logic [1:0] sat_loss_count;
    logic [2:0] sat_state_dbg;

    int n_asserts = 0;
    int n_fail    = 0;

    pix_clk_rst_ctrl u_dut (
        .clk          (clk),
        .rst          (rst),
        .pll_lock     (pll_lock),
        .soft_rst_req (soft_rst_req),
        .clr_lost     (clr_lost),
        .rst_n_out    (rst_n_out),
        .ready        (ready),
        .lock_lost    (lock_lost),
        .loss_count   (loss_count),
        .state_dbg    (state_dbg)
    );

    pix_clk_rst_ctrl #(.CNT_W(2)) u_sat (
        .clk          (clk),
        .rst          (rst),
        .pll_lock     (pll_lock),
        .soft_rst_req (soft_rst_req),
        .clr_lost     (clr_lost),
        .rst_n_out    (sat_rst_n_out),
        .ready        (sat_ready),
        .lock_lost    (sat_lock_lost),
        .loss_count   (sat_loss_count),
        .state_dbg    (sat_state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called one step after T0 (FSM just entered FILTER). A soft request
    // inside HOLD must be ignored, so release timing stays T0+25/29/33, ready T0+34.
    task automatic check_release(input string tag);
        step(16);
        chk({tag, "_hold_state"}, 32'(state_dbg), 32'd2);
        chk({tag, "_hold_rst"}, 32'(rst_n_out), 32'd0);
        step(2);
        soft_rst_req = 1'b1;
        step(1);
        soft_rst_req = 1'b0;
        step(5);
        chk({tag, "_rel_state"}, 32'(state_dbg), 32'd3);
        chk({tag, "_rel_rst0"}, 32'(rst_n_out), 32'd0);
        step(1);
        chk({tag, "_ch0_up"}, 32'(rst_n_out), 32'd1);
        step(3);
        chk({tag, "_ch1_wait"}, 32'(rst_n_out), 32'd1);
        step(1);
        chk({tag, "_ch1_up"}, 32'(rst_n_out), 32'd3);
        step(3);
        chk({tag, "_ch2_wait"}, 32'(rst_n_out), 32'd3);
        step(1);
        chk({tag, "_ch2_up"}, 32'(rst_n_out), 32'd7);
        chk({tag, "_run_state"}, 32'(state_dbg), 32'd4);
        chk({tag, "_ready_late"}, 32'(ready), 32'd0);
        step(1);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        chk({tag, "_run_rst"}, 32'(rst_n_out), 32'd7);
    endtask

    // From RUN: drop lock, optionally coincide soft/clr with the loss edge,
    // then restore lock and re-check the full sequence.
    task automatic loss_cycle(input string tag, input logic with_soft, input logic with_clr,
                              input logic [31:0] exp_cnt, input logic [31:0] exp_sat);
        pll_lock = 1'b0;
        step(2);
        chk({tag, "_pre_ready"}, 32'(ready), 32'd1);
        chk({tag, "_pre_rst"}, 32'(rst_n_out), 32'd7);
        soft_rst_req = with_soft;
        clr_lost     = with_clr;
        step(1);
        soft_rst_req = 1'b0;
        clr_lost     = 1'b0;
        chk({tag, "_lost_state"}, 32'(state_dbg), 32'd5);
        chk({tag, "_lost_rst"}, 32'(rst_n_out), 32'd0);
        chk({tag, "_lost_ready"}, 32'(ready), 32'd0);
        chk({tag, "_lock_lost"}, 32'(lock_lost), 32'd1);
        chk({tag, "_loss_count"}, 32'(loss_count), exp_cnt);
        chk({tag, "_sat_count"}, 32'(sat_loss_count), exp_sat);
        pll_lock = 1'b1;
        step(1);
        chk({tag, "_idle"}, 32'(state_dbg), 32'd0);
        step(2);
        chk({tag, "_filter"}, 32'(state_dbg), 32'd1);
        check_release(tag);
    endtask

    initial begin
        rst          = 1'b0;
        pll_lock     = 1'b1;
        soft_rst_req = 1'b0;
        clr_lost     = 1'b0;

        // Reset state
        step(2);
        chk("rst_rst_n_out", 32'(rst_n_out), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_lock_lost", 32'(lock_lost), 32'd0);
        chk("rst_loss_count", 32'(loss_count), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);

        // Steady lock: T0 is the third edge after reset release
        rst = 1'b1;
        step(2);
        chk("t1_idle", 32'(state_dbg), 32'd0);
        step(1);
        chk("t1_filter", 32'(state_dbg), 32'd1);
        check_release("t1");
        chk("t1_loss_count", 32'(loss_count), 32'd0);

        // Soft reset in RUN, then again in RELEASE after channel 0 is up
        soft_rst_req = 1'b1;
        step(1);
        soft_rst_req = 1'b0;
        chk("t4_hold", 32'(state_dbg), 32'd2);
        chk("t4_rst", 32'(rst_n_out), 32'd0);
        chk("t4_ready", 32'(ready), 32'd0);
        step(7);
        chk("t4_hold7", 32'(state_dbg), 32'd2);
        step(1);
        chk("t4_rel", 32'(state_dbg), 32'd3);
        chk("t4_rel_rst", 32'(rst_n_out), 32'd0);
        step(1);
        chk("t4_ch0", 32'(rst_n_out), 32'd1);
        soft_rst_req = 1'b1;
        step(1);
        soft_rst_req = 1'b0;
        chk("t4b_hold", 32'(state_dbg), 32'd2);
        chk("t4b_rst", 32'(rst_n_out), 32'd0);
        step(8);
        chk("t4b_rel", 32'(rst_n_out), 32'd0);
        step(1);
        chk("t4b_ch0", 32'(rst_n_out), 32'd1);
        step(4);
        chk("t4b_ch1", 32'(rst_n_out), 32'd3);
        step(4);
        chk("t4b_ch2", 32'(rst_n_out), 32'd7);
        chk("t4b_ready_late", 32'(ready), 32'd0);
        step(1);
        chk("t4b_ready", 32'(ready), 32'd1);
        chk("t4_lock_lost", 32'(lock_lost), 32'd0);
        chk("t4_loss_count", 32'(loss_count), 32'd0);

        // One-cycle lock glitch seen by the FSM at FILTER cycle 10
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        step(10);
        chk("t2_filter", 32'(state_dbg), 32'd1);
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        step(1);
        chk("t2_still_filter", 32'(state_dbg), 32'd1);
        step(1);
        chk("t2_back_idle", 32'(state_dbg), 32'd0);
        step(1);
        chk("t2_refilter", 32'(state_dbg), 32'd1);
        check_release("t2");
        chk("t2_loss_count", 32'(loss_count), 32'd0);

        // Asynchronous reset mid-RELEASE, then identical restart
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        step(3);
        chk("t6_filter", 32'(state_dbg), 32'd1);
        step(25);
        chk("t6_only_ch0", 32'(rst_n_out), 32'd1);
        step(2);
        rst = 1'b0;
        #1;
        chk("t6_async_rst", 32'(rst_n_out), 32'd0);
        chk("t6_async_state", 32'(state_dbg), 32'd0);
        chk("t6_async_ready", 32'(ready), 32'd0);
        step(1);
        rst = 1'b1;
        step(3);
        chk("t6_refilter", 32'(state_dbg), 32'd1);
        check_release("t6");

        // Lock loss in RUN and recovery
        loss_cycle("t3", 1'b0, 1'b0, 32'd1, 32'd1);
        clr_lost = 1'b1;
        step(1);
        clr_lost = 1'b0;
        chk("clr_lock_lost", 32'(lock_lost), 32'd0);
        chk("clr_keeps_count", 32'(loss_count), 32'd1);

        // Loss with soft request, loss with clear, then saturation of CNT_W=2
        loss_cycle("t5a", 1'b1, 1'b0, 32'd2, 32'd2);
        loss_cycle("t5b", 1'b0, 1'b1, 32'd3, 32'd3);
        loss_cycle("t5c", 1'b0, 1'b0, 32'd4, 32'd3);
        loss_cycle("t5d", 1'b0, 1'b0, 32'd5, 32'd3);
        clr_lost = 1'b1;
        step(1);
        clr_lost = 1'b0;
        chk("final_clr", 32'(lock_lost), 32'd0);
        chk("final_count", 32'(loss_count), 32'd5);
        chk("final_sat", 32'(sat_loss_count), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
